// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and dump state encoding for the register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// rtl/regfile_dump_fsm.sv - streams every register entry out one beat per accepted handshake
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dump_start,
    input  logic              dump_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] load_index,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = {ADDR_W{1'b1}};

    dump_state_e       state, state_next;
    logic [ADDR_W-1:0] index, index_next;
    logic [DATA_W-1:0] data, data_next;

    // Kept apart from the next-state logic: load_data is looked up from load_index.
    assign load_index = (state == STREAM) ? index + 1'b1 : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            data  <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
            data  <= data_next;
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        data_next  = data;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = STREAM;
                    index_next = '0;
                    data_next  = load_data;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (index == LAST_INDEX) begin
                        state_next = DONE;
                    end else begin
                        index_next = load_index;
                        data_next  = load_data;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign dump_valid = (state == STREAM);
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);
    assign dump_index = index;
    assign dump_data  = data;

endmodule

// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port register file with write bypass and debug dump stream
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic                     DumpStart,
    input  logic                     DumpReady,
    output logic                     DumpValid,
    output logic [ADDR_W-1:0]        DumpIndex,
    output logic [DATA_W-1:0]        DumpData,
    output logic                     DumpBusy,
    output logic                     DumpDone
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              write_en;
    logic [ADDR_W-1:0] dump_load_index;
    logic [DATA_W-1:0] dump_load_data;

    assign write_en = RegWrite && !(ZERO_REG && (WriteRegister == '0));

    // Value an index holds as seen this cycle; fwd selects same-cycle write forwarding.
    function automatic logic [DATA_W-1:0] entry_value(input logic [ADDR_W-1:0] idx,
                                                      input logic fwd);
        if (ZERO_REG && (idx == '0))
            return '0;
        if (fwd && RegWrite && (idx == WriteRegister))
            return WriteData;
        return regs[idx];
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (write_en) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    always_comb begin
        ReadData = '0;
        for (int k = 0; k < NUM_RD; k++)
            ReadData[k*DATA_W +: DATA_W] = entry_value(ReadRegister[k*ADDR_W +: ADDR_W], BYPASS);
    end

    // Dump beats always see a same-cycle write, independent of the read-port bypass setting.
    assign dump_load_data = entry_value(dump_load_index, 1'b1);

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_fsm (
        .clock      (Clock),
        .reset      (Reset),
        .dump_start (DumpStart),
        .dump_ready (DumpReady),
        .load_data  (dump_load_data),
        .load_index (dump_load_index),
        .dump_valid (DumpValid),
        .dump_index (DumpIndex),
        .dump_data  (DumpData),
        .dump_busy  (DumpBusy),
        .dump_done  (DumpDone)
    );

endmodule

// File: tb/tb_register_file_mp.sv
// tb/tb_register_file_mp.sv - self-checking bench for register_file_mp (bypass and no-bypass instances)
module tb_register_file_mp;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  ReadRegister;
    logic [63:0] rd_a, rd_b;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        DumpStart, DumpReady;
    logic        DumpValid, DumpBusy, DumpDone;
    logic [4:0]  DumpIndex;
    logic [31:0] DumpData;
    logic        b_valid, b_busy, b_done;
    logic [4:0]  b_index;
    logic [31:0] b_data;

    int n_checks = 0;
    int n_err    = 0;

    always #5 Clock = ~Clock;

    register_file_mp dut_a (
        .Clock(Clock), .Reset(Reset), .ReadRegister(ReadRegister), .ReadData(rd_a),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .DumpStart(DumpStart), .DumpReady(DumpReady), .DumpValid(DumpValid),
        .DumpIndex(DumpIndex), .DumpData(DumpData), .DumpBusy(DumpBusy), .DumpDone(DumpDone)
    );

    register_file_mp #(.BYPASS(1'b0)) dut_b (
        .Clock(Clock), .Reset(Reset), .ReadRegister(ReadRegister), .ReadData(rd_b),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .DumpStart(DumpStart), .DumpReady(DumpReady), .DumpValid(b_valid),
        .DumpIndex(b_index), .DumpData(b_data), .DumpBusy(b_busy), .DumpDone(b_done)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: array contents plus the expected dump beat
    logic [31:0] mem [32];
    bit          model_ok = 0;
    bit          m_valid, m_busy, m_done;
    int          m_idx;
    logic [31:0] m_data;

    function automatic logic [31:0] exp_read(input int idx, input bit byp);
        if (idx == 0) return 32'h0;
        if (byp && RegWrite && (int'(WriteRegister) == idx)) return WriteData;
        return mem[idx];
    endfunction

    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            m_valid = 0; m_busy = 0; m_done = 0; m_idx = 0; m_data = 32'h0;
            model_ok = 1;
        end else begin
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_busy) begin
                if (DumpReady) begin
                    if (m_idx == 31) begin
                        m_valid = 0;
                        m_done  = 1;
                    end else begin
                        m_idx  = m_idx + 1;
                        m_data = exp_read(m_idx, 1);
                    end
                end
            end else if (DumpStart) begin
                m_busy = 1; m_valid = 1; m_idx = 0;
                m_data = exp_read(0, 1);
            end
            if (RegWrite && WriteRegister != 5'd0) mem[WriteRegister] = WriteData;
        end
    end

    int          beat_idx[$];
    logic [31:0] beat_data[$];

    always @(negedge Clock) begin
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rd_a%0d", k), rd_a[k*32 +: 32], exp_read(int'(ReadRegister[k*5 +: 5]), 1));
                chk($sformatf("rd_b%0d", k), rd_b[k*32 +: 32], exp_read(int'(ReadRegister[k*5 +: 5]), 0));
            end
            chk("dump_valid", DumpValid, m_valid);
            chk("dump_busy", DumpBusy, m_busy);
            chk("dump_done", DumpDone, m_done);
            chk("dump_index", DumpIndex, m_idx);
            chk("dump_data", DumpData, m_data);
            chk("b_dump_valid", b_valid, m_valid);
            chk("b_dump_done", b_done, m_done);
            chk("b_dump_index", b_index, m_idx);
            chk("b_dump_data", b_data, m_data);
            if (DumpValid && DumpReady && !Reset) begin
                beat_idx.push_back(int'(DumpIndex));
                beat_data.push_back(DumpData);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_beats(input string tag);
        bit order_ok = 1;
        chk({tag, "_beats"}, beat_idx.size(), 32);
        foreach (beat_idx[j]) if (beat_idx[j] != j) order_ok = 0;
        chk({tag, "_order"}, order_ok, 1);
    endtask

    task automatic wait_done(input int limit, output int done_at);
        done_at = 0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge Clock);
            if (DumpDone) begin
                done_at = k;
                break;
            end
        end
    endtask

    initial begin
        int  done_at;
        bit  wrote, done_seen, found, no_done, all_zero;

        Reset = 1; ReadRegister = '0; RegWrite = 0; WriteRegister = '0; WriteData = '0;
        DumpStart = 0; DumpReady = 0;
        repeat (2) tick();
        Reset = 0;

        ReadRegister = {5'd31, 5'd0};
        @(negedge Clock);
        chk("reset_read0", rd_a[31:0], 32'h0);
        chk("reset_read31", rd_a[63:32], 32'h0);
        chk("reset_dump_data", DumpData, 32'h0);
        tick();
        for (int i = 0; i < 32; i++) begin
            ReadRegister = {5'(31 - i), 5'(i)};
            tick();
        end

        RegWrite = 1; WriteRegister = 5'd8; WriteData = 32'hFFFF_FFF0; ReadRegister = {5'd8, 5'd8};
        @(negedge Clock);
        chk("bypass_same_cycle", rd_a[31:0], 32'hFFFF_FFF0);
        chk("nobypass_same_cycle", rd_b[31:0], 32'h0);
        tick();
        RegWrite = 0;
        @(negedge Clock);
        chk("nobypass_next_cycle", rd_b[31:0], 32'hFFFF_FFF0);
        tick();

        RegWrite = 1; WriteRegister = 5'd0; WriteData = 32'hDEAD_BEEF; ReadRegister = {5'd0, 5'd0};
        @(negedge Clock);
        chk("zero_bypass_suppressed", rd_a[31:0], 32'h0);
        tick();
        RegWrite = 0;
        @(negedge Clock);
        chk("zero_after_write", rd_a[31:0], 32'h0);
        tick();

        for (int i = 0; i < 32; i++) begin
            RegWrite = 1; WriteRegister = 5'(i); WriteData = 32'(i * 3);
            tick();
        end
        RegWrite = 0;

        beat_idx.delete(); beat_data.delete();
        DumpStart = 1; DumpReady = 1;
        tick();
        DumpStart = 0;
        wait_done(40, done_at);
        chk("dump_done_cycle", done_at, 33);
        check_beats("dump1");
        chk("dump1_beat31", beat_data[31], 32'd93);
        chk("dump1_beat8", beat_data[8], 32'd24);
        tick();

        beat_idx.delete(); beat_data.delete();
        DumpStart = 1; DumpReady = 0;
        tick();
        DumpStart = 0; wrote = 0; done_seen = 0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            RegWrite = 0;
            if (DumpValid && DumpIndex == 5'd5 && !wrote) begin
                DumpReady = 0; RegWrite = 1; WriteRegister = 5'd5; WriteData = 32'h5555_0000;
                wrote = 1;
            end else begin
                DumpReady = ~DumpReady;
            end
            @(negedge Clock);
            if (DumpDone) done_seen = 1;
            tick();
        end
        RegWrite = 0;
        chk("dump2_done", done_seen, 1);
        check_beats("dump2");
        chk("dump2_beat5_held", beat_data[5], 32'd15);
        chk("dump2_beat6", beat_data[6], 32'd18);
        ReadRegister = {5'd5, 5'd5};
        @(negedge Clock);
        chk("write_during_dump", rd_a[31:0], 32'h5555_0000);
        tick();

        DumpStart = 1; DumpReady = 1;
        tick();
        DumpStart = 0; found = 0;
        for (int c = 0; c < 50; c++) begin
            if (DumpValid && DumpIndex == 5'd10) begin
                found = 1;
                break;
            end
            tick();
        end
        chk("reached_beat10", found, 1);
        Reset = 1;
        tick();
        Reset = 0; ReadRegister = {5'd8, 5'd5};
        @(negedge Clock);
        chk("rst_mid_valid", DumpValid, 0);
        chk("rst_mid_busy", DumpBusy, 0);
        chk("rst_cleared5", rd_a[31:0], 32'h0);
        chk("rst_cleared8", rd_a[63:32], 32'h0);
        no_done = 1;
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge Clock);
            if (DumpDone) no_done = 0;
        end
        chk("rst_no_done", no_done, 1);
        tick();

        beat_idx.delete(); beat_data.delete();
        DumpStart = 1;
        tick();
        DumpStart = 0;
        @(negedge Clock);
        chk("restart_valid", DumpValid, 1);
        chk("restart_index", DumpIndex, 0);
        wait_done(40, done_at);
        chk("restart_done", done_at != 0, 1);
        check_beats("dump3");
        all_zero = 1;
        foreach (beat_data[j]) if (beat_data[j] !== 32'h0) all_zero = 0;
        chk("dump3_all_zero", all_zero, 1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file for the MIPS datapath: N combinational read ports, one synchronous write port on the rising edge with same-cycle write-to-read bypass, optional hardwired zero register, and a synchronous reset that clears all entries. A valid/ready dump port streams the whole register array, one entry per accepted beat, to the debug unit.

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register index width; DEPTH = 2**ADDR_W entries.
- NUM_RD, 2: number of read ports (>=1).
- ZERO_REG, 1: 1 makes entry 0 read as 0 and ignore writes.
- BYPASS, 1: 1 forwards WriteData to read ports addressing WriteRegister in the same cycle.

- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- ReadRegister  in  NUM_RD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W].
- RegWrite  in  1  write enable.
- WriteRegister  in  ADDR_W  write index.
- WriteData  in  DATA_W  write value.
- DumpStart  in  1  one-cycle request to begin a dump.
- DumpReady  in  1  consumer accepts current beat.
- DumpValid  out  1  DumpIndex/DumpData hold a valid beat.
- DumpIndex  out  ADDR_W  index of current beat.
- DumpData  out  DATA_W  value of entry DumpIndex.
- DumpBusy  out  1  dump in progress.
- DumpDone  out  1  one-cycle pulse after last beat accepted.

## Operation
- Write: on rising edge with RegWrite=1, entry[WriteRegister] <= WriteData; if ZERO_REG=1 and WriteRegister=0 the write is dropped.
- Read: combinational from array. With BYPASS=1, if RegWrite=1 and ReadRegister_k == WriteRegister (and not zero-reg index 0), ReadData_k = WriteData. ZERO_REG=1 forces index 0 to read 0 regardless.
- Reset: all entries cleared to 0; dump FSM to IDLE.
- Dump FSM states: IDLE, STREAM, DONE.
  - IDLE: DumpStart=1 -> STREAM, load beat for index 0. DumpStart with Reset=1 ignored.
  - STREAM: DumpValid=1. DumpReady=1 and DumpIndex<DEPTH-1 -> load index+1, stay. DumpReady=1 and DumpIndex=DEPTH-1 -> DONE, DumpValid<=0. DumpReady=0 -> hold index and data unchanged.
  - DONE: DumpDone=1 for one cycle -> IDLE.
- Beat load: DumpData captures entry value at load time, including a same-cycle write to that index (bypass rule applies regardless of BYPASS). Later writes do not alter a held beat.
- DumpStart while DumpBusy=1 is ignored. Register writes proceed normally during a dump.

## Timing
- Reset values: DumpValid=0, DumpBusy=0, DumpDone=0, DumpIndex=0, DumpData=0; ReadData=0 for all indices after reset edge (array cleared).
- Write latency: visible on ReadData same cycle via bypass (BYPASS=1), otherwise the cycle after the write edge.
- Dump: DumpStart sampled at edge t -> DumpValid=1, DumpIndex=0 from t+1. With DumpReady held high, DEPTH beats on consecutive cycles, DumpDone high on cycle t+DEPTH+1, DumpBusy high t+1..t+DEPTH+1.
- DumpBusy = (state != IDLE).
- Reset mid-dump: next cycle IDLE, all dump outputs at reset values, no DumpDone pulse.
- DumpIndex wrap not possible: FSM exits at DEPTH-1.

## Structure
- Package regfile_pkg: dump state enum (IDLE, STREAM, DONE), default parameter constants (DATA_W, ADDR_W, NUM_RD).
- One sub-module: regfile_dump_fsm (state, index counter, beat capture handshake); array, write, read/bypass logic in top.

## Test plan
- Reset, then read all 32 indices on both ports -> every ReadData = 0.
- RegWrite=1, WriteRegister=8, WriteData=32'hFFFF_FFF0, ReadRegister0=8 same cycle -> ReadData0=32'hFFFF_FFF0 that cycle (BYPASS=1); with BYPASS=0 only next cycle.
- Write 32'hDEAD_BEEF to index 0 with ZERO_REG=1 -> reads of index 0 return 0, bypass suppressed.
- Write entry i = i*3, DumpStart pulse, DumpReady=1 -> 32 beats index 0..31, data 0..93, DumpDone one cycle after beat 31.
- Dump with DumpReady toggled 1/0 each cycle and write to index 5 while beat 5 held -> beat 5 data unchanged, total 32 beats, no index skipped or repeated.
- Assert Reset at beat 10 of a dump -> DumpValid/DumpBusy 0 next cycle, no DumpDone, array cleared; new DumpStart restarts at index 0.
